card_deal_scheduler: RTL
========================

Name: card_deal_scheduler

Overview:
- Sequences and shares the single card source (card generator) between three consumers: player hand, split hand and dealer.
- Runs the opening deal in the fixed order player, dealer, player, dealer.
- Afterwards serves hit, split-hit and dealer-draw requests one card at a time using round-robin arbitration.
- Tracks the shoe count and requests a reshuffle when the shoe is exhausted.
- Sits between the game FSM / coin logic and the card generator.

Parameters:
- DECK_SIZE, 52, cards per shoe before a reshuffle; fits in 6 bits.
- CARD_W, 4, card value width.
- MAX_CARD, 10, largest legal card value; legal values are 1..MAX_CARD.

Ports:
- clk  in  1  system clock.
- reset  in  1  one clock; reset is asynchronous and active-low.
- deal_start  in  1  one-cycle pulse that starts the opening 4-card deal.
- req_player  in  1  level request; held until gnt_player.
- req_split  in  1  level request; held until gnt_split.
- req_dealer  in  1  level request; held until gnt_dealer.
- src_req  out  1  card request to the generator; held until src_valid.
- src_valid  in  1  generator presents a card this cycle.
- src_card  in  CARD_W  card value from the generator.
- gnt_player  out  1  one-cycle pulse; card_out is for the player.
- gnt_split  out  1  one-cycle pulse; card_out is for the split hand.
- gnt_dealer  out  1  one-cycle pulse; card_out is for the dealer.
- card_out  out  CARD_W  delivered card; valid only with a gnt pulse.
- init_done  out  1  high once the 4-card opening deal completes; cleared by deal_start.
- busy  out  1  high in every state except IDLE and SERVE.
- shuffle_req  out  1  held high while waiting for the reshuffle.
- shuffle_done  in  1  one-cycle pulse from the generator: shoe refilled.
- cards_left  out  6  cards remaining in the shoe.

Behaviour:
- Reset values: state IDLE; all gnt_* low; src_req 0; card_out 0; init_done 0; shuffle_req 0; cards_left DECK_SIZE; round-robin pointer at player; deal index 0.
- States:
  - IDLE: only deal_start is accepted; requests are ignored. deal_start -> DEAL (deal index 0, init_done 0).
  - DEAL: src_req high. On src_valid with a legal card: register the card, decrement cards_left, -> DGNT.
  - DGNT (1 cycle): pulse the gnt for the current deal index (0: player, 1: dealer, 2: player, 3: dealer) and drive card_out.
    - Index 3 -> SERVE with init_done 1.
    - Otherwise increment the index and -> DEAL.
  - SERVE: accepts requests and deal_start.
    - deal_start takes priority over requests: -> DEAL with index 0.
    - Otherwise, if any req_* is high, latch the winner -> FETCH.
    - Round-robin order is player, split, dealer. The last-served requester becomes lowest priority.
  - FETCH: src_req high; on a legal src_valid -> GNT.
  - GNT (1 cycle): pulse the latched requester's gnt with card_out. Advance the pointer past that requester. -> SERVE.
  - SHUF: shuffle_req high; on shuffle_done, reload cards_left to DECK_SIZE and return to the saved state (DEAL, FETCH or SERVE).
- Latency:
  - Legal src_valid at cycle t gives the gnt pulse at t+1.
  - Minimum request-to-grant time is 3 cycles (SERVE -> FETCH -> GNT, with src_valid arriving in the first FETCH cycle).
  - At most one card is in flight at any time.
- Illegal card (src_card == 0 or > MAX_CARD): discarded, not counted, src_req stays high, state unchanged.
- src_valid outside DEAL/FETCH is ignored.
- Shoe exhaustion:
  - When cards_left reaches 0 after a grant, the next state is SHUF instead of DEAL, FETCH or SERVE. The return state is saved.
  - If cards_left is 0 when a fetch would start, enter SHUF first.
  - src_req is 0 in SHUF.
- deal_start outside IDLE/SERVE is ignored.
- A request that drops before it is granted still completes its latched fetch. The card is granted anyway; it is the consumer's responsibility to accept it.
- Simultaneous requests:
  - Exactly one grant per card.
  - At most one gnt_* is high in any cycle; a bench assertion checks this.
- Asynchronous reset mid-fetch: src_req drops immediately; a late src_valid is ignored.
- cards_left arithmetic is 6-bit unsigned, never decrements below 0, and saturates at DECK_SIZE on reload.

Decomposition:
- Shared package blackjack_pkg holds:
  - the state enum;
  - requester encoding (REQ_PLAYER=0, REQ_SPLIT=1, REQ_DEALER=2);
  - the opening-deal order table;
  - CARD_W, MAX_CARD and DECK_SIZE constants.
- One natural sub-module: rr_arbiter3, a 3-way round-robin arbiter with a last-grant pointer, reusable for the coin and bet paths.

Test Plan:
1. Opening deal: reset release, deal_start, generator returns 7,5,9,10 each 1 cycle after src_req. Expect gnt_player/7, gnt_dealer/5, gnt_player/9, gnt_dealer/10; init_done=1; cards_left=48.
2. Round-robin: after the opening deal, hold req_player, req_split and req_dealer together. Expect grants in order player, split, dealer, player; never two gnt_* in the same cycle.
3. Illegal cards: during FETCH the generator returns 0, then 12, then 4. Expect only one grant, with card_out=4, and cards_left decremented by 1. src_req stays high throughout.
4. Shoe exhaustion: DECK_SIZE=5, opening deal, one hit. Expect cards_left=0, shuffle_req=1, src_req=0 with a pending req_dealer. shuffle_done -> cards_left=5, then gnt_dealer.
5. Reset mid-fetch: assert reset during FETCH with src_valid arriving one cycle later. Expect src_req=0 asynchronously, no gnt pulse, state IDLE, cards_left=52.
6. deal_start in SERVE with req_player high: expect a new opening deal (first grant to the player from DEAL, init_done dropped to 0). The request is served only after init_done returns to 1.

Source files
------------

// File: rtl/blackjack_pkg.sv
// Shared types and constants for the card dealing path: state encoding,
// requester encoding, opening-deal order and shoe/card sizing.
package blackjack_pkg;

  localparam int CARD_W    = 4;
  localparam int MAX_CARD  = 10;
  localparam int DECK_SIZE = 52;
  localparam int CNT_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DEAL  = 3'd1,
    ST_DGNT  = 3'd2,
    ST_SERVE = 3'd3,
    ST_FETCH = 3'd4,
    ST_GNT   = 3'd5,
    ST_SHUF  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    REQ_PLAYER = 2'd0,
    REQ_SPLIT  = 2'd1,
    REQ_DEALER = 2'd2
  } req_e;

  // Opening deal order: player, dealer, player, dealer.
  function automatic req_e deal_target(input logic [1:0] idx);
    req_e r;
    case (idx)
      2'd0:    r = REQ_PLAYER;
      2'd1:    r = REQ_DEALER;
      2'd2:    r = REQ_PLAYER;
      default: r = REQ_DEALER;
    endcase
    return r;
  endfunction

  // Next index in a 3-entry rotation (0 -> 1 -> 2 -> 0).
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

endpackage

// File: rtl/card_deal_scheduler_arb.sv
// rr_arbiter3: 3-way round-robin arbiter. ptr_q names the requester with
// the highest priority; after a served grant it moves just past the winner
// so the last-served requester drops to lowest priority.
module rr_arbiter3
  import blackjack_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       adv,
  input  logic [1:0] adv_idx,
  output logic [1:0] gnt_idx,
  output logic       gnt_any
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] c0, c1, c2;

  // Search the requests starting at the pointer and wrapping around.
  always_comb begin
    c0      = ptr_q;
    c1      = rr_next(c0);
    c2      = rr_next(c1);
    gnt_any = 1'b1;
    gnt_idx = c0;
    if (req[c0])      gnt_idx = c0;
    else if (req[c1]) gnt_idx = c1;
    else if (req[c2]) gnt_idx = c2;
    else              gnt_any = 1'b0;
    ptr_d = adv ? rr_next(adv_idx) : ptr_q;
  end

  // Pointer register; starts with the player at top priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 2'd0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/card_deal_scheduler.sv
// Shares the single card generator between player, split hand and dealer:
// fixed 4-card opening deal, then round-robin single-card service, with
// shoe tracking and reshuffle handshake.
//
// state | meaning
// IDLE  | waiting for deal_start, requests ignored
// DEAL  | opening deal: requesting a card for deal index idx_q
// DGNT  | opening deal: grant pulse for deal index idx_q
// SERVE | waiting for a request or a new deal_start
// FETCH | requesting a card for the latched requester sel_q
// GNT   | grant pulse to sel_q, pointer advances
// SHUF  | shoe empty, waiting for shuffle_done, then back to ret_q
module card_deal_scheduler #(
  parameter int CARD_W    = blackjack_pkg::CARD_W,
  parameter int MAX_CARD  = blackjack_pkg::MAX_CARD,
  parameter int DECK_SIZE = blackjack_pkg::DECK_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              deal_start,
  input  logic              req_player,
  input  logic              req_split,
  input  logic              req_dealer,
  output logic              src_req,
  input  logic              src_valid,
  input  logic [CARD_W-1:0] src_card,
  output logic              gnt_player,
  output logic              gnt_split,
  output logic              gnt_dealer,
  output logic [CARD_W-1:0] card_out,
  output logic              init_done,
  output logic              busy,
  output logic              shuffle_req,
  input  logic              shuffle_done,
  output logic [5:0]        cards_left
);

  import blackjack_pkg::*;

  localparam logic [CNT_W-1:0]  SHOE_FULL = CNT_W'(DECK_SIZE);
  localparam logic [CARD_W-1:0] CARD_MAX  = CARD_W'(MAX_CARD);

  state_e            state_q, state_d, ret_q, ret_d, tgt;
  logic              tgt_go;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        sel_q, sel_d;
  logic              src_req_q, src_req_d;
  logic              gnt_p_q, gnt_p_d, gnt_s_q, gnt_s_d, gnt_d_q, gnt_d_d;
  logic [CARD_W-1:0] card_out_q, card_out_d;
  logic              init_done_q, init_done_d;
  logic              busy_q, busy_d;
  logic              shuffle_req_q, shuffle_req_d;
  logic [CNT_W-1:0]  cards_left_q, cards_left_d;
  logic              card_ok;
  logic              gnt_fire;
  logic [1:0]        gnt_who;
  logic [1:0]        arb_idx;
  logic              arb_any;

  assign card_ok = src_valid && (src_card != '0) && (src_card <= CARD_MAX);

  rr_arbiter3 u_arb (
    .clk     (clk),
    .rst_n   (reset),
    .req     ({req_dealer, req_split, req_player}),
    .adv     (state_q == ST_GNT),
    .adv_idx (sel_q),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // Next-state and next-output computation; every fetch/serve entry is
  // diverted to SHUF when the shoe is empty, remembering the intended target.
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    idx_d        = idx_q;
    sel_d        = sel_q;
    card_out_d   = card_out_q;
    init_done_d  = init_done_q;
    cards_left_d = cards_left_q;
    gnt_fire     = 1'b0;
    gnt_who      = REQ_PLAYER;
    tgt          = state_q;
    tgt_go       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (deal_start) begin
          idx_d       = 2'd0;
          init_done_d = 1'b0;
          tgt         = ST_DEAL;
          tgt_go      = 1'b1;
        end
      end
      ST_DEAL: begin
        if (card_ok) begin
          card_out_d   = src_card;
          cards_left_d = (cards_left_q != '0) ? cards_left_q - 1'b1 : '0;
          gnt_fire     = 1'b1;
          gnt_who      = deal_target(idx_q);
          state_d      = ST_DGNT;
        end
      end
      ST_DGNT: begin
        tgt_go = 1'b1;
        if (idx_q == 2'd3) begin
          init_done_d = 1'b1;
          tgt         = ST_SERVE;
        end else begin
          idx_d = idx_q + 2'd1;
          tgt   = ST_DEAL;
        end
      end
      ST_SERVE: begin
        if (deal_start) begin
          idx_d       = 2'd0;
          init_done_d = 1'b0;
          tgt         = ST_DEAL;
          tgt_go      = 1'b1;
        end else if (arb_any) begin
          sel_d  = arb_idx;
          tgt    = ST_FETCH;
          tgt_go = 1'b1;
        end
      end
      ST_FETCH: begin
        if (card_ok) begin
          card_out_d   = src_card;
          cards_left_d = (cards_left_q != '0) ? cards_left_q - 1'b1 : '0;
          gnt_fire     = 1'b1;
          gnt_who      = sel_q;
          state_d      = ST_GNT;
        end
      end
      ST_GNT: begin
        tgt    = ST_SERVE;
        tgt_go = 1'b1;
      end
      ST_SHUF: begin
        if (shuffle_done) begin
          cards_left_d = SHOE_FULL;
          state_d      = ret_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tgt_go) begin
      if (cards_left_q == '0) begin
        state_d = ST_SHUF;
        ret_d   = tgt;
      end else begin
        state_d = tgt;
      end
    end
    gnt_p_d       = gnt_fire && (gnt_who == REQ_PLAYER);
    gnt_s_d       = gnt_fire && (gnt_who == REQ_SPLIT);
    gnt_d_d       = gnt_fire && (gnt_who == REQ_DEALER);
    src_req_d     = (state_d == ST_DEAL) || (state_d == ST_FETCH);
    shuffle_req_d = (state_d == ST_SHUF);
    busy_d        = !((state_d == ST_IDLE) || (state_d == ST_SERVE));
  end

  // State and registered outputs; reset drops src_req at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ret_q         <= ST_IDLE;
      idx_q         <= 2'd0;
      sel_q         <= REQ_PLAYER;
      src_req_q     <= 1'b0;
      gnt_p_q       <= 1'b0;
      gnt_s_q       <= 1'b0;
      gnt_d_q       <= 1'b0;
      card_out_q    <= '0;
      init_done_q   <= 1'b0;
      busy_q        <= 1'b0;
      shuffle_req_q <= 1'b0;
      cards_left_q  <= SHOE_FULL;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      idx_q         <= idx_d;
      sel_q         <= sel_d;
      src_req_q     <= src_req_d;
      gnt_p_q       <= gnt_p_d;
      gnt_s_q       <= gnt_s_d;
      gnt_d_q       <= gnt_d_d;
      card_out_q    <= card_out_d;
      init_done_q   <= init_done_d;
      busy_q        <= busy_d;
      shuffle_req_q <= shuffle_req_d;
      cards_left_q  <= cards_left_d;
    end
  end

  assign src_req     = src_req_q;
  assign gnt_player  = gnt_p_q;
  assign gnt_split   = gnt_s_q;
  assign gnt_dealer  = gnt_d_q;
  assign card_out    = card_out_q;
  assign init_done   = init_done_q;
  assign busy        = busy_q;
  assign shuffle_req = shuffle_req_q;
  assign cards_left  = cards_left_q;

endmodule
